reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Eight-entry, 16-bit general register file sitting directly downstream of the instruction controller.
- Consumes the controller's register strobes: source select, destination select, write enable, drive enable and PC increment.
- Supplies the program counter to the memory address path, the operands to the ALU, and register data to the shared data bus.
- Fixed roles: r0 is the PC, r1 is the link register (JSR target), r7 is the scratch register used for immediate and memory operands.

Parameters:
- WIDTH, 16, data width of each register and of every data port
- NREGS, 8, number of registers; select width is fixed at 3 bits
- RESET_PC, 16'h0000, value loaded into r0 on reset

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- src_sel  input  3  source register select (read port A, bus drive, copy source)
- dst_sel  input  3  destination register select (read port B, write target)
- in_en  input  1  write enable for register dst_sel
- out_en  input  1  drive regs[src_sel] onto bus_out; when asserted with in_en, write source is internal
- pc_inc  input  1  increment r0 by 1
- bus_in  input  WIDTH  write data from the shared bus (controller immediate/jump value, memory read data, ALU result)
- bus_out  output  WIDTH  regs[src_sel] when out_en is high, else 0
- bus_out_valid  output  1  equals out_en; downstream address/data latches qualify on this
- src_data  output  WIDTH  regs[src_sel], combinational, to ALU operand A
- dst_data  output  WIDTH  regs[dst_sel], combinational, to ALU operand B
- pc  output  WIDTH  regs[0], combinational

Behaviour:
- Reset: asynchronous, active-high.
  - While rst is high: r0 = RESET_PC, r1..r7 = 0.
  - Reset mid-instruction discards any pending write or increment; state is valid from the first rising edge after rst falls.
  - Outputs in reset: pc = RESET_PC; src_data and dst_data reflect the reset register contents; bus_out = 0 unless out_en is high.
- Reads: all read ports are combinational from current register state, so no read latency. A write is visible on the read ports the cycle after the edge that commits it (no write-through bypass).
- Write, in_en = 1 at a rising edge:
  - Target is regs[dst_sel].
  - Data is regs[src_sel] if out_en = 1 (register-to-register copy; the value is sampled pre-edge), else bus_in.
  - src_sel == dst_sel with out_en = 1 is a no-op write and must not corrupt the register.
- PC increment, pc_inc = 1 at a rising edge: r0 <= r0 + 1, modulo 2^WIDTH (16'hFFFF wraps to 16'h0000). No flag is produced.
- Simultaneous pc_inc and in_en with dst_sel == 0: the write wins and the increment is dropped. This is the jump/branch case.
- Simultaneous pc_inc and in_en with dst_sel != 0: both take effect in the same edge.
- JSR sequence (src_sel = 0, dst_sel = 1, in_en = 1, out_en = 1): r1 <= r0 pre-edge value. If pc_inc is also high, r1 still gets the pre-increment value.
- Narrow values on bus_in (8-bit immediates, 12-bit jump targets) arrive already zero-extended by the producer; reg_file performs no extension.
- No handshake: every enable is single-cycle and level-sampled at the edge. An enable held for N cycles acts N times; for example, pc_inc held 3 cycles advances PC by 3.
- Every register is writable, including r0. There is no write protection.

Decomposition:
- Shared package tiny16_pkg holds:
  - WIDTH
  - REG_PC = 3'd0, REG_LINK = 3'd1, REG_TMP = 3'd7
  - the select width constant (3)
- The controller and this block both import these constants.
- No sub-module: one register array, one incrementer, one write-data mux and three read muxes, all in a single module.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with RESET_PC = 16'h0010 -> pc = 16'h0010 immediately; all other registers read 0 on src_data/dst_data after release.
- Fetch increment: out_en = 1, src_sel = 0 for one cycle, then pc_inc held 2 cycles from pc = 16'hFFFF -> bus_out = 16'hFFFF while out_en is high, pc = 16'h0000 then 16'h0001.
- Immediate load: in_en = 1, dst_sel = 3, bus_in = 16'h00A5, out_en = 0 -> next cycle, dst_data with dst_sel = 3 reads 16'h00A5; bus_out = 0.
- Copy and same-register write: r2 = 16'h1234, then src_sel = 2, dst_sel = 5, in_en = out_en = 1 -> r5 = 16'h1234. Then src_sel = dst_sel = 5 with in_en = out_en = 1 -> r5 stays 16'h1234.
- JSR: pc = 16'h0040, src_sel = 0, dst_sel = 1, in_en = out_en = pc_inc = 1 -> r1 = 16'h0040, pc = 16'h0041. Next cycle, dst_sel = 0, in_en = 1, bus_in = 16'h0123, pc_inc = 1 -> pc = 16'h0123 (write beats increment).
- Reset mid-write: in_en = 1, dst_sel = 4, bus_in = 16'hBEEF, with rst pulsed before the edge -> r4 = 0 after reset; no partial update.

Source files
------------

// File: rtl/tiny16_pkg.sv
// Shared constants for the tiny16 core: data width, select width and the
// fixed register roles used by both the controller and reg_file.
package tiny16_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SEL_W = 3;

  localparam logic [SEL_W-1:0] REG_PC   = 3'd0;
  localparam logic [SEL_W-1:0] REG_LINK = 3'd1;
  localparam logic [SEL_W-1:0] REG_TMP  = 3'd7;

endpackage : tiny16_pkg

// File: rtl/reg_file.sv
// reg_file: eight-entry general register file (r0 = PC, r1 = link,
// r7 = scratch).
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   src_sel, dst_sel  read port A / bus / copy source, read port B / write target
//   in_en             write regs[dst_sel]; the data is regs[src_sel] when
//                     out_en is high, otherwise bus_in
//   out_en            drive regs[src_sel] onto bus_out
//   pc_inc            r0 <= r0 + 1 (a write to r0 in the same cycle wins)
//   bus_in            write data from the shared bus
//   bus_out           regs[src_sel] when out_en is high, else 0
//   bus_out_valid     equals out_en
//   src_data          regs[src_sel], combinational
//   dst_data          regs[dst_sel], combinational
//   pc                regs[0], combinational
module reg_file
  import tiny16_pkg::SEL_W;
  import tiny16_pkg::REG_PC;
#(
  parameter int unsigned           WIDTH    = tiny16_pkg::WIDTH,
  parameter int unsigned           NREGS    = 8,
  parameter logic [WIDTH-1:0]      RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] src_sel,
  input  logic [SEL_W-1:0] dst_sel,
  input  logic             in_en,
  input  logic             out_en,
  input  logic             pc_inc,
  input  logic [WIDTH-1:0] bus_in,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_out_valid,
  output logic [WIDTH-1:0] src_data,
  output logic [WIDTH-1:0] dst_data,
  output logic [WIDTH-1:0] pc
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic [WIDTH-1:0] wr_data;

  // Read muxes: purely combinational, no write-through bypass.
  always_comb begin
    src_data      = regs_q[src_sel];
    dst_data      = regs_q[dst_sel];
    pc            = regs_q[REG_PC];
    bus_out_valid = out_en;
    bus_out       = out_en ? regs_q[src_sel] : '0;
  end

  // Next state: increment first, then the write so a write to r0 beats pc_inc.
  // Copy data comes from regs_q, so src == dst is a harmless self-write and
  // JSR captures the pre-increment PC.
  always_comb begin
    regs_d  = regs_q;
    wr_data = out_en ? regs_q[src_sel] : bus_in;
    if (pc_inc) begin
      regs_d[REG_PC] = regs_q[REG_PC] + WIDTH'(1);
    end
    if (in_en) begin
      regs_d[dst_sel] = wr_data;
    end
  end

  // Register array with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
      regs_q[REG_PC] <= RESET_PC;
    end else begin
      regs_q <= regs_d;
    end
  end

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: a table of directed vectors (inputs plus
// the combinational outputs expected before the edge that applies them) and
// hand-written reset sequences.
module tb_reg_file;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk;
  logic        rst;
  logic [2:0]  src_sel;
  logic [2:0]  dst_sel;
  logic        in_en;
  logic        out_en;
  logic        pc_inc;
  logic [15:0] bus_in;
  logic [15:0] bus_out;
  logic        bus_out_valid;
  logic [15:0] src_data;
  logic [15:0] dst_data;
  logic [15:0] pc;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        in_en;
    logic        out_en;
    logic        pc_inc;
    logic [15:0] bus_in;
    logic [15:0] e_pc;
    logic [15:0] e_src;
    logic [15:0] e_dst;
    logic [15:0] e_bus;
  } vec_t;

  vec_t vq[$];

  reg_file #(
    .WIDTH   (16),
    .NREGS   (8),
    .RESET_PC(RST_PC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src_sel      (src_sel),
    .dst_sel      (dst_sel),
    .in_en        (in_en),
    .out_en       (out_en),
    .pc_inc       (pc_inc),
    .bus_in       (bus_in),
    .bus_out      (bus_out),
    .bus_out_valid(bus_out_valid),
    .src_data     (src_data),
    .dst_data     (dst_data),
    .pc           (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] s, input logic [2:0] d, input logic ie,
                       input logic oe, input logic pi, input logic [15:0] b);
    src_sel = s;
    dst_sel = d;
    in_en   = ie;
    out_en  = oe;
    pc_inc  = pi;
    bus_in  = b;
  endtask

  task automatic add(input logic [2:0] s, input logic [2:0] d, input logic ie,
                     input logic oe, input logic pi, input logic [15:0] b,
                     input logic [15:0] ep, input logic [15:0] es,
                     input logic [15:0] ed, input logic [15:0] eb);
    vec_t v;
    v = '{s, d, ie, oe, pi, b, ep, es, ed, eb};
    vq.push_back(v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    drive(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Vectors start from the reset state: r0 = 0010, others 0.
    //   src   dst   in    out   inc   bus_in     pc        src       dst       bus_out
    add(3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0010, 16'h0000, 16'h0000);
    add(3'd2, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    add(3'd3, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    add(3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0010, 16'h0000, 16'h0000, 16'h0000);
    // Load PC = FFFF, fetch with out_en, then two increments wrap through 0.
    add(3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0010, 16'h0010, 16'h0010, 16'h0000);
    add(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    add(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000);
    add(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    add(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0001, 16'h0001, 16'h0000);
    // Immediate load r3 = 00A5.
    add(3'd0, 3'd3, 1'b1, 1'b0, 1'b0, 16'h00A5, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    add(3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h00A5, 16'h00A5, 16'h0000);
    // r2 = 1234, copy r2 -> r5, then self-copy r5 -> r5.
    add(3'd0, 3'd2, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0001, 16'h0001, 16'h0000, 16'h0000);
    add(3'd2, 3'd5, 1'b1, 1'b1, 1'b0, 16'hDEAD, 16'h0001, 16'h1234, 16'h0000, 16'h1234);
    add(3'd5, 3'd5, 1'b1, 1'b1, 1'b0, 16'hDEAD, 16'h0001, 16'h1234, 16'h1234, 16'h1234);
    add(3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h1234, 16'h1234, 16'h0000);
    // PC = 0040, JSR with pc_inc, then jump with pc_inc (write wins).
    add(3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0040, 16'h0001, 16'h0001, 16'h0001, 16'h0000);
    add(3'd0, 3'd1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0040, 16'h0040, 16'h0000, 16'h0040);
    add(3'd1, 3'd0, 1'b1, 1'b0, 1'b1, 16'h0123, 16'h0041, 16'h0040, 16'h0041, 16'h0000);
    add(3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0123, 16'h0123, 16'h0040, 16'h0000);
    // pc_inc together with a write to r6: both land.
    add(3'd0, 3'd6, 1'b1, 1'b0, 1'b1, 16'h5A5A, 16'h0123, 16'h0123, 16'h0000, 16'h0000);
    add(3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0124, 16'h5A5A, 16'h0124, 16'h0000);
    // pc_inc held three cycles.
    add(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0124, 16'h0124, 16'h0124, 16'h0000);
    add(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0125, 16'h0125, 16'h0125, 16'h0000);
    add(3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0126, 16'h0126, 16'h0126, 16'h0000);
    add(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0127, 16'h0127, 16'h0127, 16'h0000);
    // Copy PC into the scratch register r7.
    add(3'd0, 3'd7, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0127, 16'h0127, 16'h0000, 16'h0127);
    add(3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0127, 16'h0127, 16'h0127, 16'h0000);

    // Reset applied from time 0 is visible without any clock edge.
    #3;
    chk("reset_pc_async", pc, RST_PC);
    chk("reset_r0_src", src_data, RST_PC);
    chk("reset_bus_idle", bus_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].src, vq[i].dst, vq[i].in_en, vq[i].out_en, vq[i].pc_inc, vq[i].bus_in);
      #1;
      chk($sformatf("v%0d_pc", i), pc, vq[i].e_pc);
      chk($sformatf("v%0d_src", i), src_data, vq[i].e_src);
      chk($sformatf("v%0d_dst", i), dst_data, vq[i].e_dst);
      chk($sformatf("v%0d_bus", i), bus_out, vq[i].e_bus);
      chk($sformatf("v%0d_valid", i), 16'(bus_out_valid), 16'(vq[i].out_en));
    end

    // Reset mid-write: pending r4 <= BEEF is discarded, r6 and PC restored.
    @(negedge clk);
    drive(3'd6, 3'd4, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_pc", pc, RST_PC);
    chk("midrst_r6", src_data, 16'h0000);
    chk("midrst_r4", dst_data, 16'h0000);
    // While in reset, out_en still drives the bus from reset contents.
    drive(3'd0, 3'd4, 1'b1, 1'b1, 1'b1, 16'hBEEF);
    #1;
    chk("inrst_bus", bus_out, RST_PC);
    chk("inrst_valid", 16'(bus_out_valid), 16'h0001);
    @(negedge clk);
    drive(3'd7, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0000);
    rst = 1'b0;
    #1;
    chk("postrst_r4", dst_data, 16'h0000);
    chk("postrst_r7", src_data, 16'h0000);
    chk("postrst_pc", pc, RST_PC);
    @(negedge clk);
    drive(3'd1, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("postrst_r1", src_data, 16'h0000);
    chk("postrst_r5", dst_data, 16'h0000);
    chk("postrst_pc_hold", pc, RST_PC);

    // First edge after release updates state normally.
    @(negedge clk);
    drive(3'd0, 3'd4, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    @(negedge clk);
    drive(3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    chk("postrst_write", dst_data, 16'hBEEF);
    chk("postrst_inc", pc, 16'h0011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_file
